crc_pkt_stim_gen: RTL and testbench
===================================

CRC_PKT_STIM_GEN -- requirements
Module: crc_pkt_stim_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are named clk and rst_n.
REQ-002 Parameter DWIDTH, default 512: flit data width in bits, multiple of 64; NB = DWIDTH/8.
REQ-003 Parameter BYTE_BITS, default 12: width of the packet-length field, in bytes.
REQ-004 Parameter PKT_LIMIT, default 16'd100: number of packets per run; 0 = unlimited.
REQ-005 Parameter GAP, default 0: idle cycles inserted between packets, range 0-255.
REQ-006 Parameter SEED, default 32'h19911102: initial xorshift32 state, nonzero.
REQ-007 clk  in  1  clock.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 start  in  1  level; run enable.
REQ-010 cfg_len  in  BYTE_BITS  fixed packet length in bytes; 0 = random length.
REQ-011 ready  in  1  downstream accept.
REQ-012 dout  out  DWIDTH  flit data; byte i = dout[DWIDTH-1-8i -: 8] (MSB-first).
REQ-013 byteEn  out  NB  byteEn[NB-1-i] = byte i valid.
REQ-014 dlast  out  1  last flit of packet.
REQ-015 flitEn  out  1  flit valid.
REQ-016 pkt_cnt  out  16  packets completed this run.
REQ-017 done  out  1  PKT_LIMIT reached.
REQ-018 busy  out  1  state is not IDLE and not DONE.

Function
REQ-019 States SHALL be IDLE, LOAD, SEND, GAPW and DONE.
REQ-020 IDLE->LOAD at the edge where start=1 is sampled.
REQ-021 LOAD SHALL latch len = cfg_len if cfg_len!=0; otherwise len = rng[BYTE_BITS-1:0], with 0 mapped to 1.
REQ-022 In LOAD the rng SHALL advance one xorshift32 step (x^=x<<13; x^=x>>17; x^=x<<5); the rng SHALL not advance in any other state.
REQ-023 LOAD->SEND next edge; flitEn SHALL be 1 with the first flit in the cycle after LOAD.
REQ-024 A packet SHALL consist of ceil(len/NB) flits.
REQ-025 Every non-last flit SHALL have byteEn all ones.
REQ-026 The last flit SHALL have its top r bits of byteEn set, where r = len - NB*(flits-1), with dlast=1.
REQ-027 Byte k of packet p SHALL equal (p[7:0] + k) mod 256, where k is the byte offset in the packet; invalid byte lanes SHALL be 0.
REQ-028 A flit SHALL transfer only when flitEn & ready.
REQ-029 While flitEn=1 and ready=0, dout, byteEn and dlast SHALL hold stable.
REQ-030 On a transfer of a dlast flit, pkt_cnt SHALL increment by 1 (16-bit wrap when PKT_LIMIT=0).
REQ-031 After a transfer of a dlast flit: if PKT_LIMIT!=0 and pkt_cnt+1==PKT_LIMIT -> DONE with done=1.
REQ-032 After a transfer of a dlast flit not going to DONE: if start=0 -> IDLE; else if GAP>0 -> GAPW; else -> LOAD.
REQ-033 GAPW SHALL hold flitEn=0 for exactly GAP cycles, then -> LOAD (or -> IDLE if start=0).
REQ-034 Deasserting start mid-packet SHALL not truncate the packet; the generator stops after the packet's dlast transfer.
REQ-035 start=0 in IDLE or DONE SHALL clear pkt_cnt and done next edge; DONE is left only via start=0.
REQ-036 flitEn SHALL be 0 in IDLE, LOAD, GAPW and DONE.
REQ-037 The pattern base p SHALL be pkt_cnt at LOAD.

Reset
REQ-038 rst_n=0 at an edge SHALL force IDLE, rng=SEED, pkt_cnt=0, done=0, busy=0, flitEn=0, dlast=0, byteEn=0 and dout=0, regardless of state, including mid-packet.
REQ-039 The first flit after reset release SHALL appear no earlier than 2 cycles after start is sampled.

Verification
REQ-040 DWIDTH=64, cfg_len=20, ready=1, start=1 -> 3 flits: byteEn FF,FF,F0; dout 0x0001020304050607, 0x08090A0B0C0D0E0F, 0x1011121300000000; dlast on flit 3; pkt_cnt 0->1.
REQ-041 DWIDTH=64, cfg_len=20, ready=0 for 3 cycles during flit 2 -> flit 2 held unchanged for 4 cycles; total packet duration 6 cycles; no duplicated or dropped flit.
REQ-042 DWIDTH=64, cfg_len=8, PKT_LIMIT=4, GAP=2 -> 4 single-flit packets with byteEn FF and dlast=1, exactly 2 idle cycles between packets; done=1 and pkt_cnt=4; dout of packet 3 = 0x030405060708090A; start=0 -> pkt_cnt=0 and done=0.
REQ-043 cfg_len=0 with the random length drawing 0 -> len=1: single flit, byteEn=0x80 (DWIDTH=64), dlast=1.
REQ-044 rst_n=0 at flit 2 of a 3-flit packet -> next cycle flitEn=0, state IDLE, pkt_cnt=0; after release with start=1 the first packet uses rng=SEED, and its length is identical to the first run.
REQ-045 start dropped during flit 1 of a 3-flit packet -> flits 2-3 are still sent; then state IDLE with busy=0.

Source files
------------

// File: rtl/crc_pkt_stim_gen.sv
// Packet stimulus generator: emits flit streams of fixed or xorshift32-random length
// with an incrementing byte pattern, honouring ready back-pressure and an optional packet limit.
module crc_pkt_stim_gen #(
    parameter int unsigned DWIDTH    = 512,
    parameter int unsigned BYTE_BITS = 12,
    parameter logic [15:0] PKT_LIMIT = 16'd100,
    parameter int unsigned GAP       = 0,
    parameter logic [31:0] SEED      = 32'h19911102
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BYTE_BITS-1:0]  cfg_len,
    input  logic                  ready,
    output logic [DWIDTH-1:0]     dout,
    output logic [DWIDTH/8-1:0]   byteEn,
    output logic                  dlast,
    output logic                  flitEn,
    output logic [15:0]           pkt_cnt,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned NB = DWIDTH / 8;
    localparam int unsigned GW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GAPW,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          rng_q, rng_d;
    logic [BYTE_BITS-1:0] len_q, len_d;
    logic [BYTE_BITS-1:0] off_q, off_d;
    logic [7:0]           base_q, base_d;
    logic [15:0]          pkt_cnt_q, pkt_cnt_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [DWIDTH-1:0]    dout_q, dout_d;
    logic [NB-1:0]        be_q, be_d;
    logic                 dlast_q, dlast_d;
    logic                 flit_en_q, flit_en_d;

    logic [BYTE_BITS-1:0] len_load_c;
    logic [BYTE_BITS-1:0] len_src_c;
    logic [BYTE_BITS-1:0] off_src_c;
    logic [7:0]           base_src_c;
    logic [BYTE_BITS-1:0] rem_c;
    logic [DWIDTH-1:0]    bld_data_c;
    logic [NB-1:0]        bld_be_c;
    logic                 bld_last_c;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Packet length chosen at LOAD; a random draw of zero becomes a one-byte packet.
    always_comb begin
        len_load_c = cfg_len;
        if (cfg_len == '0) begin
            len_load_c = rng_q[BYTE_BITS-1:0];
            if (rng_q[BYTE_BITS-1:0] == '0) begin
                len_load_c = BYTE_BITS'(1);
            end
        end
    end

    // LOAD builds the first flit; SEND builds the one after the flit being shown.
    always_comb begin
        len_src_c  = len_q;
        off_src_c  = off_q + BYTE_BITS'(NB);
        base_src_c = base_q;
        if (state_q == S_LOAD) begin
            len_src_c  = len_load_c;
            off_src_c  = '0;
            base_src_c = pkt_cnt_q[7:0];
        end
    end

    always_comb begin
        rem_c      = len_src_c - off_src_c;
        bld_data_c = '0;
        bld_be_c   = '0;
        for (int i = 0; i < int'(NB); i++) begin
            if (int'(rem_c) > i) begin
                bld_be_c[NB-1-i]             = 1'b1;
                bld_data_c[DWIDTH-1-8*i -: 8] = base_src_c + 8'(off_src_c) + 8'(i);
            end
        end
        bld_last_c = (int'(rem_c) <= int'(NB));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        rng_d     = rng_q;
        len_d     = len_q;
        off_d     = off_q;
        base_d    = base_q;
        pkt_cnt_d = pkt_cnt_q;
        gap_d     = gap_q;
        dout_d    = dout_q;
        be_d      = be_q;
        dlast_d   = dlast_q;
        flit_en_d = flit_en_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    pkt_cnt_d = '0;
                end
            end
            S_LOAD: begin
                len_d     = len_load_c;
                rng_d     = xorshift32(rng_q);
                base_d    = pkt_cnt_q[7:0];
                off_d     = '0;
                dout_d    = bld_data_c;
                be_d      = bld_be_c;
                dlast_d   = bld_last_c;
                flit_en_d = 1'b1;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (flit_en_q && ready) begin
                    if (dlast_q) begin
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                        dout_d    = '0;
                        be_d      = '0;
                        dlast_d   = 1'b0;
                        flit_en_d = 1'b0;
                        if ((PKT_LIMIT != 16'd0) && ((pkt_cnt_q + 16'd1) == PKT_LIMIT)) begin
                            state_d = S_DONE;
                        end else if (!start) begin
                            state_d = S_IDLE;
                        end else if (GAP > 0) begin
                            state_d = S_GAPW;
                            gap_d   = GW'(GAP - 1);
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        off_d   = off_src_c;
                        dout_d  = bld_data_c;
                        be_d    = bld_be_c;
                        dlast_d = bld_last_c;
                    end
                end
            end
            S_GAPW: begin
                if (gap_q == '0) begin
                    state_d = start ? S_LOAD : S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d   = S_IDLE;
                    pkt_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_LOAD) || (state_d == S_SEND) || (state_d == S_GAPW);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rng_q     <= SEED;
            len_q     <= '0;
            off_q     <= '0;
            base_q    <= '0;
            pkt_cnt_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            gap_q     <= '0;
            dout_q    <= '0;
            be_q      <= '0;
            dlast_q   <= 1'b0;
            flit_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rng_q     <= rng_d;
            len_q     <= len_d;
            off_q     <= off_d;
            base_q    <= base_d;
            pkt_cnt_q <= pkt_cnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            gap_q     <= gap_d;
            dout_q    <= dout_d;
            be_q      <= be_d;
            dlast_q   <= dlast_d;
            flit_en_q <= flit_en_d;
        end
    end

    assign dout    = dout_q;
    assign byteEn  = be_q;
    assign dlast   = dlast_q;
    assign flitEn  = flit_en_q;
    assign pkt_cnt = pkt_cnt_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_crc_pkt_stim_gen.sv
// Directed bench for crc_pkt_stim_gen: three 64-bit instances covering fixed length,
// back-pressure, reset replay of the random length, packet limit with gap, and zero-length draw.
module tb_crc_pkt_stim_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start0, ready0, dlast0, fe0, done0, busy0;
    logic [11:0] len0;
    logic [63:0] dout0;
    logic [7:0]  be0;
    logic [15:0] cnt0;

    logic        start1, ready1, dlast1, fe1, done1, busy1;
    logic [11:0] len1;
    logic [63:0] dout1;
    logic [7:0]  be1;
    logic [15:0] cnt1;

    logic        start2, ready2, dlast2, fe2, done2, busy2;
    logic [11:0] len2;
    logic [63:0] dout2;
    logic [7:0]  be2;
    logic [15:0] cnt2;

    crc_pkt_stim_gen #(.DWIDTH(64)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cfg_len(len0), .ready(ready0),
        .dout(dout0), .byteEn(be0), .dlast(dlast0), .flitEn(fe0),
        .pkt_cnt(cnt0), .done(done0), .busy(busy0)
    );

    crc_pkt_stim_gen #(.DWIDTH(64), .PKT_LIMIT(16'd4), .GAP(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cfg_len(len1), .ready(ready1),
        .dout(dout1), .byteEn(be1), .dlast(dlast1), .flitEn(fe1),
        .pkt_cnt(cnt1), .done(done1), .busy(busy1)
    );

    crc_pkt_stim_gen #(.DWIDTH(64), .SEED(32'h12345000)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cfg_len(len2), .ready(ready2),
        .dout(dout2), .byteEn(be2), .dlast(dlast2), .flitEn(fe2),
        .pkt_cnt(cnt2), .done(done2), .busy(busy2)
    );

    int tests = 0;
    int fails = 0;
    int fe0_cycles = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (fe0) fe0_cycles++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp1 [4];
        logic [7:0]  last_be;
        logic [63:0] last_dout;
        int          n;
        int          idle;
        bit          seen;

        exp1[0] = 64'h0001020304050607;
        exp1[1] = 64'h0102030405060708;
        exp1[2] = 64'h0203040506070809;
        exp1[3] = 64'h030405060708090A;

        rst_n  = 1'b0;
        start0 = 1'b0; ready0 = 1'b1; len0 = 12'd20;
        start1 = 1'b0; ready1 = 1'b1; len1 = 12'd8;
        start2 = 1'b0; ready2 = 1'b1; len2 = 12'd0;
        repeat (3) tick();

        chk("rst_flitEn", 64'(fe0), 64'd0);
        chk("rst_dout", dout0, 64'd0);
        chk("rst_byteEn", 64'(be0), 64'd0);
        chk("rst_dlast", 64'(dlast0), 64'd0);
        chk("rst_pkt_cnt", 64'(cnt0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);

        // Fixed 20-byte packet, then a second packet with start dropped during its first flit.
        rst_n  = 1'b1;
        start0 = 1'b1;
        tick();
        chk("load_no_flit", 64'(fe0), 64'd0);
        chk("load_busy", 64'(busy0), 64'd1);
        tick();
        chk("p0f1_fe", 64'(fe0), 64'd1);
        chk("p0f1_dout", dout0, 64'h0001020304050607);
        chk("p0f1_be", 64'(be0), 64'hFF);
        chk("p0f1_last", 64'(dlast0), 64'd0);
        tick();
        chk("p0f2_dout", dout0, 64'h08090A0B0C0D0E0F);
        chk("p0f2_be", 64'(be0), 64'hFF);
        tick();
        chk("p0f3_dout", dout0, 64'h1011121300000000);
        chk("p0f3_be", 64'(be0), 64'hF0);
        chk("p0f3_last", 64'(dlast0), 64'd1);
        tick();
        chk("p0_cnt", 64'(cnt0), 64'd1);
        chk("p0_gap_fe", 64'(fe0), 64'd0);
        chk("p0_gap_busy", 64'(busy0), 64'd1);
        start0 = 1'b0;
        tick();
        chk("p1f1_dout", dout0, 64'h0102030405060708);
        tick();
        chk("p1f2_dout", dout0, 64'h090A0B0C0D0E0F10);
        tick();
        chk("p1f3_dout", dout0, 64'h1112131400000000);
        chk("p1f3_last", 64'(dlast0), 64'd1);
        tick();
        chk("stop_fe", 64'(fe0), 64'd0);
        chk("stop_busy", 64'(busy0), 64'd0);
        chk("stop_cnt", 64'(cnt0), 64'd2);
        tick();
        chk("idle_clear_cnt", 64'(cnt0), 64'd0);

        // Back-pressure: ready low for three cycles while flit 2 is shown.
        start0     = 1'b1;
        fe0_cycles = 0;
        tick();
        tick();
        chk("bp_f1_dout", dout0, 64'h0001020304050607);
        tick();
        ready0 = 1'b0;
        chk("bp_f2_c1", dout0, 64'h08090A0B0C0D0E0F);
        tick();
        chk("bp_f2_c2", dout0, 64'h08090A0B0C0D0E0F);
        chk("bp_f2_c2_be", 64'(be0), 64'hFF);
        chk("bp_f2_c2_last", 64'(dlast0), 64'd0);
        tick();
        chk("bp_f2_c3", dout0, 64'h08090A0B0C0D0E0F);
        tick();
        chk("bp_f2_c4", dout0, 64'h08090A0B0C0D0E0F);
        ready0 = 1'b1;
        tick();
        chk("bp_f3_dout", dout0, 64'h1011121300000000);
        chk("bp_f3_last", 64'(dlast0), 64'd1);
        start0 = 1'b0;
        tick();
        chk("bp_end_fe", 64'(fe0), 64'd0);
        chk("bp_flit_cycles", 64'(fe0_cycles), 64'd6);
        chk("bp_cnt", 64'(cnt0), 64'd1);
        tick();

        // Random length from SEED (low bits 0x102 = 258 bytes -> 33 flits, last byteEn C0).
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        len0   = 12'd0;
        start0 = 1'b1;
        n = 0; seen = 1'b0; last_be = '0; last_dout = '0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (fe0) begin
                n++;
                if (dlast0) begin
                    seen = 1'b1; last_be = be0; last_dout = dout0;
                end
            end
        end
        chk("rnd1_seen_last", 64'(seen), 64'd1);
        chk("rnd1_flits", 64'(n), 64'd33);
        chk("rnd1_last_be", 64'(last_be), 64'hC0);
        chk("rnd1_last_dout", last_dout, 64'h0001000000000000);
        tick();
        tick();
        chk("rnd2_f1_dout", dout0, 64'h0102030405060708);
        chk("rnd2_f1_last", 64'(dlast0), 64'd0);
        tick();
        chk("rnd2_f2_dout", dout0, 64'h090A0B0C0D0E0F10);
        rst_n = 1'b0;
        tick();
        chk("midrst_fe", 64'(fe0), 64'd0);
        chk("midrst_cnt", 64'(cnt0), 64'd0);
        chk("midrst_busy", 64'(busy0), 64'd0);
        chk("midrst_dout", dout0, 64'd0);
        chk("midrst_be", 64'(be0), 64'd0);
        chk("midrst_last", 64'(dlast0), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rerun_load_no_flit", 64'(fe0), 64'd0);
        n = 0; seen = 1'b0; last_be = '0; last_dout = '0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (fe0) begin
                n++;
                if (dlast0) begin
                    seen = 1'b1; last_be = be0; last_dout = dout0;
                    start0 = 1'b0;
                end
            end
        end
        chk("rerun_seen_last", 64'(seen), 64'd1);
        chk("rerun_flits", 64'(n), 64'd33);
        chk("rerun_last_be", 64'(last_be), 64'hC0);
        tick();
        chk("rerun_idle_busy", 64'(busy0), 64'd0);

        // Packet limit 4 with GAP=2: between flits, two GAPW cycles then the LOAD cycle.
        start1 = 1'b1;
        for (int p = 0; p < 4; p++) begin
            idle = 0;
            while (!fe1 && idle < 20) begin
                tick();
                idle++;
            end
            chk("lim_fe", 64'(fe1), 64'd1);
            chk("lim_idle", 64'(idle), (p == 0) ? 64'd2 : 64'd3);
            chk("lim_dout", dout1, exp1[p]);
            chk("lim_be", 64'(be1), 64'hFF);
            chk("lim_last", 64'(dlast1), 64'd1);
            chk("lim_cnt", 64'(cnt1), 64'(p));
            tick();
        end
        chk("lim_done", 64'(done1), 64'd1);
        chk("lim_cnt4", 64'(cnt1), 64'd4);
        chk("lim_done_fe", 64'(fe1), 64'd0);
        chk("lim_done_busy", 64'(busy1), 64'd0);
        tick();
        chk("lim_done_hold", 64'(done1), 64'd1);
        chk("lim_done_hold_fe", 64'(fe1), 64'd0);
        start1 = 1'b0;
        tick();
        chk("lim_clear_cnt", 64'(cnt1), 64'd0);
        chk("lim_clear_done", 64'(done1), 64'd0);

        // Random draw of zero length becomes a single one-byte flit.
        start2 = 1'b1;
        idle   = 0;
        while (!fe2 && idle < 10) begin
            tick();
            idle++;
        end
        chk("zl_fe", 64'(fe2), 64'd1);
        chk("zl_be", 64'(be2), 64'h80);
        chk("zl_last", 64'(dlast2), 64'd1);
        chk("zl_dout", dout2, 64'd0);
        start2 = 1'b0;
        tick();
        chk("zl_end_fe", 64'(fe2), 64'd0);
        chk("zl_end_busy", 64'(busy2), 64'd0);
        chk("zl_end_cnt", 64'(cnt2), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
